// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte-stream and read-side bundle for uart_rx_frame_ctrl.
// slave is the controller's view; master is the UART receiver plus consumer.
interface uart_rx_frame_ctrl_if #(
    parameter int unsigned DEPTH = 16
);
    logic [7:0]               rx_data;
    logic                     rx_done;
    logic [7:0]               rd_data;
    logic                     rd_valid;
    logic                     rd_ready;
    logic                     frame_ok;
    logic                     frame_err;
    logic [1:0]               err_code;
    logic                     busy;
    logic [$clog2(DEPTH):0]   fifo_level;

    modport slave (
        input  rx_data, rx_done, rd_ready,
        output rd_data, rd_valid, frame_ok, frame_err, err_code, busy, fifo_level
    );

    modport master (
        output rx_data, rx_done, rd_ready,
        input  rd_data, rd_valid, frame_ok, frame_err, err_code, busy, fifo_level
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frame parser (A5 LEN payload CSUM) feeding a payload FIFO that only exposes checksum-verified frames.
// Define RX_TIMEOUT_EN to abort a partial frame after TIMEOUT_CYCLES idle clocks (err_code 3).
module uart_rx_frame_ctrl #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 52080
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_rx_frame_ctrl_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    if (DEPTH < 4 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("uart_rx_frame_ctrl: DEPTH must be a power of two in 4..64 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CSUM
    } state_t;

    state_t       state_q;
    logic [AW:0]  wp_spec_q;
    logic [AW:0]  wp_com_q;
    logic [AW:0]  rp_q;
    logic [7:0]   rem_q;
    logic [7:0]   csum_q;
    logic         frame_ok_q;
    logic         frame_err_q;
    logic [1:0]   err_code_q;
    logic [7:0]   mem [DEPTH];

    logic [AW:0]  level;
    logic         rd_valid;
    logic         pop;
    logic [8:0]   len_ext;
    logic [8:0]   free_space;

    // Visible occupancy is measured against the committed pointer only.
    assign level      = wp_com_q - rp_q;
    assign rd_valid   = (level != '0);
    assign pop        = rd_valid && bus.rd_ready;
    assign len_ext    = {1'b0, bus.rx_data};
    assign free_space = 9'(DEPTH) - 9'(level);

`ifdef RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HUNT;
            wp_spec_q   <= '0;
            wp_com_q    <= '0;
            rp_q        <= '0;
            rem_q       <= '0;
            csum_q      <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'd0;
`ifdef RX_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (pop) begin
                rp_q <= rp_q + 1'b1;
            end

            if (bus.rx_done) begin
                unique case (state_q)
                    S_HUNT: begin
                        if (bus.rx_data == 8'hA5) begin
                            state_q <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (len_ext > 9'(DEPTH)) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= 2'd1;
                            state_q     <= S_HUNT;
                        end else if (len_ext > free_space) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= 2'd2;
                            state_q     <= S_HUNT;
                        end else begin
                            csum_q  <= bus.rx_data;
                            rem_q   <= bus.rx_data;
                            state_q <= (bus.rx_data == 8'd0) ? S_CSUM : S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        wp_spec_q <= wp_spec_q + 1'b1;
                        csum_q    <= csum_q ^ bus.rx_data;
                        rem_q     <= rem_q - 8'd1;
                        if (rem_q == 8'd1) begin
                            state_q <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (bus.rx_data == csum_q) begin
                            wp_com_q   <= wp_spec_q;
                            frame_ok_q <= 1'b1;
                        end else begin
                            wp_spec_q   <= wp_com_q;
                            frame_err_q <= 1'b1;
                            err_code_q  <= 2'd0;
                        end
                        state_q <= S_HUNT;
                    end
                endcase
            end

`ifdef RX_TIMEOUT_EN
            // Placed after the case so an expiry overrides nothing: it only fires on idle cycles.
            if (state_q == S_HUNT || bus.rx_done) begin
                tmo_q <= '0;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_q       <= '0;
                wp_spec_q   <= wp_com_q;
                frame_err_q <= 1'b1;
                err_code_q  <= 2'd3;
                state_q     <= S_HUNT;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
`endif
        end
    end

    // Payload storage carries no reset; rd_data is gated so it reads 0 when empty.
    always_ff @(posedge clk) begin
        if (state_q == S_PAYLOAD && bus.rx_done) begin
            mem[wp_spec_q[AW-1:0]] <= bus.rx_data;
        end
    end

    assign bus.rd_data    = rd_valid ? mem[rp_q[AW-1:0]] : 8'h00;
    assign bus.rd_valid   = rd_valid;
    assign bus.fifo_level = level;
    assign bus.frame_ok   = frame_ok_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.err_code   = err_code_q;
    assign bus.busy       = (state_q != S_HUNT);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frames plus random traffic against a queue-based frame model.
module tb_uart_rx_frame_ctrl;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TMO   = 52080;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_frame_ctrl_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_frame_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bytes of the frame being parsed, and the committed byte stream.
    logic [7:0] fbuf[$];
    logic [7:0] cq[$];
    logic       m_ok   = 1'b0;
    logic       m_err  = 1'b0;
    logic [1:0] m_code = 2'd0;
    int         idle   = 0;

    task automatic reject(input logic [1:0] code);
        m_err  = 1'b1;
        m_code = code;
        fbuf.delete();
    endtask

    task automatic model_step();
        bit         do_pop;
        int         lvl;
        logic [7:0] b;
        logic [7:0] x;
        do_pop = bus.rd_ready && (cq.size() > 0);
        lvl    = cq.size();
        m_ok   = 1'b0;
        m_err  = 1'b0;
        if (bus.rx_done) begin
            idle = 0;
            b = bus.rx_data;
            if (fbuf.size() == 0) begin
                if (b == 8'hA5) fbuf.push_back(b);
            end else if (fbuf.size() == 1) begin
                if (int'(b) > int'(DEPTH)) reject(2'd1);
                else if (int'(b) > int'(DEPTH) - lvl) reject(2'd2);
                else fbuf.push_back(b);
            end else begin
                fbuf.push_back(b);
            end
            if (fbuf.size() >= 3 && fbuf.size() == int'(fbuf[1]) + 3) begin
                x = 8'h00;
                for (int i = 1; i < fbuf.size() - 1; i++) x ^= fbuf[i];
                if (x == fbuf[fbuf.size()-1]) begin
                    for (int i = 2; i < fbuf.size() - 1; i++) cq.push_back(fbuf[i]);
                    m_ok = 1'b1;
                    fbuf.delete();
                end else begin
                    reject(2'd0);
                end
            end
        end
`ifdef RX_TIMEOUT_EN
        else if (fbuf.size() > 0) begin
            idle++;
            if (idle == int'(TMO)) begin
                reject(2'd3);
                idle = 0;
            end
        end
`endif
        if (do_pop) void'(cq.pop_front());
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            fbuf.delete();
            cq.delete();
            m_ok = 1'b0; m_err = 1'b0; m_code = 2'd0; idle = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        check("rd_valid", bus.rd_valid, cq.size() != 0);
        if (cq.size() != 0) check("rd_data", bus.rd_data, cq[0]);
        check("fifo_level", bus.fifo_level, cq.size());
        check("busy", bus.busy, fbuf.size() != 0);
        check("frame_ok", bus.frame_ok, m_ok);
        check("frame_err", bus.frame_err, m_err);
        check("err_code", bus.err_code, m_code);
    end

    task automatic step();
        @(posedge clk);
        #2;
        if (rand_rdy) bus.rd_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        step();
        bus.rx_done = 1'b0;
        bus.rx_data = 8'($urandom);
        repeat (gap) step();
    endtask

    task automatic send_frame(input int len, input bit corrupt, input int maxgap);
        logic [7:0] cs;
        logic [7:0] p;
        cs = 8'(len);
        send(8'hA5, $urandom_range(0, maxgap));
        send(8'(len), $urandom_range(0, maxgap));
        for (int i = 0; i < len; i++) begin
            p = 8'($urandom);
            cs ^= p;
            send(p, $urandom_range(0, maxgap));
        end
        if (corrupt) cs ^= 8'($urandom_range(1, 255));
        send(cs, $urandom_range(0, maxgap));
    endtask

    task automatic drain();
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (!bus.rd_valid) break;
            step();
        end
        bus.rd_ready = 1'b0;
        check("drain_empty", bus.rd_valid, 1'b0);
    endtask

    initial begin
        logic [7:0] exp3 [3];
        logic [7:0] j;
        int kind;
        exp3 = '{8'h11, 8'h22, 8'h33};
        bus.rx_data  = 8'h00;
        bus.rx_done  = 1'b0;
        bus.rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_level", bus.fifo_level, 0);
        check("rst_valid", bus.rd_valid, 0);
        check("rst_data", bus.rd_data, 8'h00);
        check("rst_busy", bus.busy, 0);
        check("rst_code", bus.err_code, 0);
        check("rst_ok", bus.frame_ok, 0);
        rst_n = 1'b1;
        step();

        // Good three-byte frame, then pop it in order.
        send(8'hA5, 1); send(8'h03, 0); send(8'h11, 2); send(8'h22, 0); send(8'h33, 1);
        send(8'h03, 0);
        check("good_ok", bus.frame_ok, 1);
        check("good_level", bus.fifo_level, 3);
        for (int i = 0; i < 3; i++) begin
            check("pop_data", bus.rd_data, exp3[i]);
            bus.rd_ready = 1'b1;
            step();
        end
        bus.rd_ready = 1'b0;
        check("popped_level", bus.fifo_level, 0);

        // Bad checksum leaves nothing visible.
        send(8'hA5, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
        send(8'h04, 0);
        check("csum_err", bus.frame_err, 1);
        check("csum_code", bus.err_code, 0);
        check("csum_level", bus.fifo_level, 0);
        check("csum_valid", bus.rd_valid, 0);

        // Oversized LEN, then an empty frame.
        send(8'hA5, 0); send(8'h11, 0);
        check("len_err", bus.frame_err, 1);
        check("len_code", bus.err_code, 1);
        check("len_hunt", bus.busy, 0);
        send(8'hA5, 1); send(8'h00, 1); send(8'h00, 0);
        check("empty_ok", bus.frame_ok, 1);
        check("empty_level", bus.fifo_level, 0);

        // Fill to 14, reject for space, then commit with a concurrent pop.
        send_frame(7, 1'b0, 1);
        send_frame(7, 1'b0, 1);
        check("fill_level", bus.fifo_level, 14);
        send(8'hA5, 1); send(8'h03, 0);
        check("space_err", bus.frame_err, 1);
        check("space_code", bus.err_code, 2);
        send(8'hA5, 1); send(8'h02, 0); send(8'hAA, 0); send(8'hBB, 1);
        bus.rd_ready = 1'b1;
        send(8'h13, 0);
        bus.rd_ready = 1'b0;
        check("concur_ok", bus.frame_ok, 1);
        check("concur_level", bus.fifo_level, 15);
        drain();

        // Reset mid-payload with committed data.
        send_frame(5, 1'b0, 0);
        check("pre_rst_level", bus.fifo_level, 5);
        send(8'hA5, 1); send(8'h04, 0); send(8'h11, 0); send(8'h22, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_level", bus.fifo_level, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_err", bus.frame_err, 0);
        step();
        rst_n = 1'b1;
        step();
        check("postrst_ok_quiet", bus.frame_ok, 0);
        send(8'hA5, 0); send(8'h01, 0); send(8'h5A, 0); send(8'h5B, 0);
        check("postrst_ok", bus.frame_ok, 1);
        check("postrst_level", bus.fifo_level, 1);
        drain();

        // Partial frame left idle.
        send(8'hA5, 0); send(8'h02, 0); send(8'h11, 0);
`ifdef RX_TIMEOUT_EN
        repeat (TMO - 1) step();
        check("tmo_early", bus.frame_err, 0);
        step();
        check("tmo_err", bus.frame_err, 1);
        check("tmo_code", bus.err_code, 3);
        check("tmo_busy", bus.busy, 0);
        check("tmo_level", bus.fifo_level, 0);
`else
        repeat (3000) step();
        check("wait_busy", bus.busy, 1);
        check("wait_noerr", bus.frame_err, 0);
        send(8'h22, 1);
        send(8'h31, 0);
        check("wait_ok", bus.frame_ok, 1);
        check("wait_level", bus.fifo_level, 2);
        drain();
`endif

        // Random traffic with random consumer back-pressure.
        rand_rdy = 1'b1;
        for (int f = 0; f < 300; f++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 5) begin
                send_frame(int'($urandom_range(0, 8)), 1'b0, 2);
            end else if (kind == 6) begin
                send_frame(int'($urandom_range(0, 6)), 1'b1, 2);
            end else if (kind == 7) begin
                send(8'hA5, $urandom_range(0, 2));
                send(8'($urandom_range(DEPTH + 1, 255)), $urandom_range(0, 2));
            end else begin
                j = 8'($urandom);
                if (j == 8'hA5) j = 8'h00;
                send(j, $urandom_range(0, 2));
            end
        end
        rand_rdy = 1'b0;
        bus.rd_ready = 1'b0;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
